// File: rtl/debug_fmt_pkg.sv
// Shared state type, ASCII constants and line-formatting helpers for the debug hex formatter.
// Build option: define DEBUG_HEX_PREFIX_EN to start every line with "0x".
package debug_fmt_pkg;

  typedef enum logic {
    IDLE,
    EMIT
  } fmt_state_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;

`ifdef DEBUG_HEX_PREFIX_EN
  localparam int PREFIX_LEN = 2;
`else
  localparam int PREFIX_LEN = 0;
`endif

  localparam int         LINE_LEN = PREFIX_LEN + 10;
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN - 1);

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (ASCII_ZERO + wide) : (8'h37 + wide);
  endfunction

  // Byte at position idx of the text line for word; digits run MSB nibble first.
  function automatic logic [7:0] line_byte(input logic [31:0] word, input logic [3:0] idx);
    logic [7:0] result;
    logic [2:0] pos;
    pos = 3'(idx - 4'(PREFIX_LEN));
    if (idx == LAST_IDX) begin
      result = ASCII_LF;
    end else if (idx == LAST_IDX - 4'd1) begin
      result = ASCII_CR;
`ifdef DEBUG_HEX_PREFIX_EN
    end else if (idx == 4'd0) begin
      result = ASCII_ZERO;
    end else if (idx == 4'd1) begin
      result = ASCII_X;
`endif
    end else begin
      result = nibble_to_ascii(4'(word >> (5'd28 - {pos, 2'b00})));
    end
    return result;
  endfunction

endpackage

// File: rtl/debug_hex_formatter_if.sv
// Debug word push port and ASCII byte stream of the debug hex formatter.
// The formatter takes the slave modport; the producer/UART side takes master.
interface debug_hex_formatter_if #(
  parameter int DROP_CNT_W = 16
);
  logic [31:0]           in_data;
  logic                  in_valid;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  fifo_full;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, fifo_full, drop_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, fifo_full, drop_cnt
  );
endinterface

// File: rtl/debug_word_fifo.sv
// Small synchronous word FIFO; the head word is visible on rdata without a pop.
// Pushes while full and pops while empty are ignored.
module debug_word_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers rely on natural wrap since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/debug_hex_formatter.sv
// Turns 32-bit debug words into "XXXXXXXX\r\n" ASCII lines for the UART, one byte per handshake.
// Build option: DEBUG_HEX_PREFIX_EN prefixes every line with "0x".
module debug_hex_formatter
  import debug_fmt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst,
  debug_hex_formatter_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  fmt_state_e            state_q, state_d;
  logic [31:0]           shift_q, shift_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [31:0]           fifo_rdata;
  logic [AW:0]           fifo_count;

  debug_word_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .wdata (bus.in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The byte for the next state is precomputed so out_data is a plain register.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          idx_d    = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (out_valid_q && bus.out_ready) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
              idx_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == EMIT);
    out_data_d  = out_valid_d ? line_byte(shift_d, idx_d) : 8'h00;
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid && fifo_full && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (fifo_full == (fifo_count == (AW+1)'(FIFO_DEPTH)));
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fifo_full = fifo_full;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: doc/debug_hex_formatter.md
# debug_hex_formatter

Converts 32-bit debug words from the core's debug port into ASCII hex text lines for the UART transmitter in the FPGA debug path. Each accepted word is buffered in a small FIFO, then emitted MSB-nibble-first as uppercase hex digits followed by CR LF, one byte per valid/ready handshake. The producer side is fire-and-forget (single-cycle valid pulses, no backpressure); words arriving when the FIFO is full are dropped and counted.

## Interface
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥2.
- DROP_CNT_W, 16: width of the saturating drop counter.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  32  debug word to format.
- in_valid  input  1  single-cycle push strobe; no ready return.
- out_data  output  8  ASCII byte to the UART transmitter.
- out_valid  output  1  out_data holds a byte awaiting acceptance.
- out_ready  input  1  transmitter accepts the byte this cycle.
- fifo_full  output  1  registered FIFO count == FIFO_DEPTH.
- drop_cnt  output  DROP_CNT_W  count of dropped words, saturating.

## Operation
- Reset, applied in the cycle rst is sampled high: out_valid=0, out_data=8'h00, fifo_full=0, drop_cnt=0, FIFO empty, FSM in IDLE. Reset mid-line abandons the partial line; no trailing CR LF.
- Push: in_valid=1 with FIFO not full writes in_data. With fifo_full=1 the word is dropped and drop_cnt increments, holding at all-ones. Full is evaluated on the registered count, so a push in the same cycle as a pop from a full FIFO is still dropped.
- FSM states:
  - IDLE: out_valid=0. When the FIFO is non-empty, pop the head into a 32-bit shift register, set the byte index to 0, and go to EMIT.
  - EMIT: out_valid=1. out_data is driven from the byte index:
    - index 0..7: hex of nibble [31-4i -: 4]; 0–9 map to 8'h30–8'h39, A–F to 8'h41–8'h46.
    - index 8: 8'h0D (CR).
    - index 9: 8'h0A (LF).
  - On a handshake (out_valid && out_ready) the index advances.
  - On the LF handshake: if the FIFO is non-empty, pop the next word and stay in EMIT with index 0 (no bubble); otherwise go to IDLE.
- out_data and out_valid are registered and stay stable while out_valid=1 and out_ready=0.
- Byte index width is 4 bits; the total line length is set by the Configuration section.

## Timing
- Latency: a push at cycle N into an empty FIFO with the FSM idle gives out_valid=1 with the first digit at N+2 (FIFO write at N, pop at N+1).
- Throughput: one byte per cycle while out_ready=1; 10 cycles per word (12 with the prefix).
- Back-to-back lines: an LF handshake at M with the FIFO non-empty gives the next word's first byte valid at M+1.
- fifo_full reflects the count after the previous edge; push and pop in the same cycle leave the count unchanged.
- out_ready high while out_valid=0 has no effect.

## Configuration
- DEBUG_HEX_PREFIX_EN defined: each line is "0x" (8'h30, 8'h78) + 8 digits + CR LF, 12 bytes; digit indices shift to 2..9, CR at 10, LF at 11.
- Undefined: 10-byte lines, as above.

## Structure
- Package debug_fmt_pkg:
  - FSM state enum (IDLE, EMIT).
  - ASCII constants for CR, LF, '0', 'x'.
  - LINE_LEN localparam, dependent on the macro.
  - Pure function nibble_to_ascii(logic [3:0]) returning logic [7:0].
- Sub-module debug_word_fifo: synchronous FIFO with parameters FIFO_DEPTH and width 32.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - rdata shows the head combinationally.
  - Pointer wrap uses the natural log2(FIFO_DEPTH) overflow.

## Test plan
- Single word: push 32'hDEADBEEF, out_ready=1 → bytes 44 45 41 44 42 45 45 46 0D 0A; first out_valid two cycles after the push; IDLE afterwards.
- Backpressure: push 32'h0123ABCD, hold out_ready=0 for 5 cycles after the first byte → out_data=8'h30 is stable throughout; the full line follows once out_ready=1.
- Overflow: out_ready=0, push 6 words with FIFO_DEPTH=4 → the first word goes to the shift register and 4 fill the FIFO, so 1 is dropped: drop_cnt=1 and fifo_full=1. Release out_ready → 5 lines in push order, no bubble between lines.
- Saturation: DROP_CNT_W=2, 6 drops while full → drop_cnt=3.
- Reset mid-line: assert rst after 3 bytes of 32'hCAFEF00D are accepted → next cycle out_valid=0, FIFO empty, drop_cnt=0; a fresh push of 32'h00000000 yields 30×8 0D 0A.
- With DEBUG_HEX_PREFIX_EN: push 32'h0000000F → 30 78 30 30 30 30 30 30 30 46 0D 0A.
